// File: rtl/bootram_bus_bridge.sv
// PicoRV32 native-bus slave for the 8 KB boot RAM built from four 2Kx8 SP
// byte-lane macros; sequences CE/WRE/AD/DI and adds write protection.
module bootram_bus_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_WIDTH  = 11,
  parameter int          RST_STRETCH = 2,
  parameter logic        WP_DEFAULT  = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  input  logic                  wp_set,
  output logic [7:0]            wp_viol_cnt,
  output logic [ADDR_WIDTH-1:0] ram_ad,
  output logic [31:0]           ram_din,
  output logic [3:0]            ram_ce,
  output logic [3:0]            ram_wre,
  output logic                  ram_oce,
  output logic                  ram_reset,
  input  logic [31:0]           ram_dout
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ad_q, ad_d;
  logic [31:0]           din_q, din_d;
  logic [3:0]            strb_q, strb_d;
  logic                  wr_q, wr_d;
  logic                  blk_q, blk_d;
  logic                  wp_q, wp_d;
  logic [7:0]            viol_q, viol_d;
  logic [3:0]            rst_cnt_q, rst_cnt_d;
  logic                  sel;
  logic                  unused;

  assign unused = ^mem_addr[1:0];

  assign sel = mem_valid &&
    (mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

  // macro output reset is held while the counter drains
  assign ram_reset   = |rst_cnt_q;
  assign ram_oce     = 1'b1;
  assign ram_ad      = ad_q;
  assign ram_din     = din_q;
  assign wp_viol_cnt = viol_q;

  always_comb begin
    state_d   = state_q;
    ad_d      = ad_q;
    din_d     = din_q;
    strb_d    = strb_q;
    wr_d      = wr_q;
    blk_d     = blk_q;
    viol_d    = viol_q;
    wp_d      = wp_set;
    rst_cnt_d = rst_cnt_q - {3'b0, ram_reset};
    ram_ce    = 4'h0;
    ram_wre   = 4'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    case (state_q)
      IDLE: begin
        if (sel && !ram_reset) begin
          ad_d    = mem_addr[ADDR_WIDTH+1:2];
          din_d   = mem_wdata;
          strb_d  = mem_wstrb;
          wr_d    = |mem_wstrb;
          blk_d   = (|mem_wstrb) & wp_q;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!wr_q) begin
          ram_ce = 4'hF;
        end else if (!blk_q) begin
          ram_ce  = strb_q;
          ram_wre = strb_q;
        end
        state_d = RESP;
      end
      RESP: begin
        mem_ready = 1'b1;
        if (!wr_q) mem_rdata = ram_dout;
        if (blk_q && viol_q != 8'hFF) viol_d = viol_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      ad_q      <= '0;
      din_q     <= '0;
      strb_q    <= '0;
      wr_q      <= 1'b0;
      blk_q     <= 1'b0;
      wp_q      <= WP_DEFAULT;
      viol_q    <= '0;
      rst_cnt_q <= 4'(RST_STRETCH);
    end else begin
      state_q   <= state_d;
      ad_q      <= ad_d;
      din_q     <= din_d;
      strb_q    <= strb_d;
      wr_q      <= wr_d;
      blk_q     <= blk_d;
      wp_q      <= wp_d;
      viol_q    <= viol_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

endmodule

// File: tb/tb_bootram_bus_bridge.sv
// Directed bench for bootram_bus_bridge with a byte-lane SP RAM model
// and a queue of expected read data.
module tb_bootram_bus_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wp_set;
  logic [7:0]  wp_viol_cnt;
  logic [10:0] ram_ad;
  logic [31:0] ram_din;
  logic [3:0]  ram_ce;
  logic [3:0]  ram_wre;
  logic        ram_oce;
  logic        ram_reset;
  logic [31:0] ram_dout;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl [0:2047];

  always #5 clk = ~clk;

  bootram_bus_bridge dut (
    .clk        (clk),
    .resetn     (resetn),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .wp_set     (wp_set),
    .wp_viol_cnt(wp_viol_cnt),
    .ram_ad     (ram_ad),
    .ram_din    (ram_din),
    .ram_ce     (ram_ce),
    .ram_wre    (ram_wre),
    .ram_oce    (ram_oce),
    .ram_reset  (ram_reset),
    .ram_dout   (ram_dout)
  );

  // four 2Kx8 SP lanes, bypass read mode, synchronous output reset
  always @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (ram_ce[n]) begin
        if (ram_wre[n]) begin
          mdl[ram_ad][8*n+:8] <= ram_din[8*n+:8];
          ram_dout[8*n+:8]    <= ram_din[8*n+:8];
        end else begin
          ram_dout[8*n+:8]    <= mdl[ram_ad][8*n+:8];
        end
      end
      if (ram_reset) ram_dout[8*n+:8] <= 8'h00;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // lat = edges from drive to ready; 0 means no response expected
  task automatic req(input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input int lat,
                     input logic [3:0] ece, input logic [3:0] ewre,
                     input logic [31:0] erd);
    bit got;
    logic [31:0] e;
    got = 1'b0;
    @(negedge clk);
    if (lat > 0) exp_q.push_back(erd);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    if (lat == 0) begin
      for (int k = 1; k <= 4; k++) begin
        @(posedge clk); #1;
        chk("unsel_ready", {31'b0, mem_ready}, 32'h0);
        chk("unsel_ce", {28'b0, ram_ce}, 32'h0);
      end
    end else begin
      for (int k = 1; k <= 8; k++) begin
        @(posedge clk); #1;
        if (k == lat - 1) begin
          chk("ce", {28'b0, ram_ce}, {28'b0, ece});
          chk("wre", {28'b0, ram_wre}, {28'b0, ewre});
          chk("ad", {21'b0, ram_ad}, {21'b0, a[12:2]});
        end
        if (mem_ready) begin
          got = 1'b1;
          mem_valid = 1'b0;
          chk("latency", 32'(k), 32'(lat));
          e = exp_q.pop_front();
          chk("rdata", mem_rdata, e);
          break;
        end
      end
      chk("ready_seen", {31'b0, got}, 32'h1);
      @(posedge clk); #1;
      chk("ready_pulse", {31'b0, mem_ready}, 32'h0);
    end
    mem_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mdl[i] = 32'h0;
    mdl[1]  = 32'h00B7A000;
    mdl[4]  = 32'h11223344;
    mdl[8]  = 32'h55667788;
    mdl[12] = 32'hCAFEF00D;
    resetn    = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    wp_set    = 1'b1;

    #12;
    chk("rst_ready", {31'b0, mem_ready}, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_ce", {28'b0, ram_ce}, 32'h0);
    chk("rst_wre", {28'b0, ram_wre}, 32'h0);
    chk("rst_ad", {21'b0, ram_ad}, 32'h0);
    chk("rst_din", ram_din, 32'h0);
    chk("rst_viol", {24'b0, wp_viol_cnt}, 32'h0);
    chk("rst_ramreset", {31'b0, ram_reset}, 32'h1);
    chk("oce", {31'b0, ram_oce}, 32'h1);

    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    chk("stretch_e1", {31'b0, ram_reset}, 32'h1);
    @(posedge clk); #1;
    chk("stretch_e2", {31'b0, ram_reset}, 32'h0);

    // request during the stretch waits for ram_reset to clear
    @(negedge clk); resetn = 1'b0;
    @(posedge clk); #2; resetn = 1'b1;
    req(32'h4, 32'h0, 4'h0, 4, 4'hF, 4'h0, 32'h00B7A000);
    req(32'h4, 32'h0, 4'h0, 2, 4'hF, 4'h0, 32'h00B7A000);

    wp_set = 1'b0;
    @(posedge clk);
    req(32'h10, 32'hDEADBEEF, 4'b0101, 2, 4'b0101, 4'b0101, 32'h0);
    req(32'h10, 32'h0, 4'h0, 2, 4'hF, 4'h0, 32'h11AD33EF);
    req(32'h10, 32'hA5A5A5A5, 4'hF, 2, 4'hF, 4'hF, 32'h0);
    req(32'h10, 32'h0, 4'h0, 2, 4'hF, 4'h0, 32'hA5A5A5A5);

    wp_set = 1'b1;
    @(posedge clk);
    req(32'h20, 32'h01020304, 4'hF, 2, 4'h0, 4'h0, 32'h0);
    chk("viol_one", {24'b0, wp_viol_cnt}, 32'd1);
    for (int i = 1; i < 300; i++)
      req(32'h20, $urandom, 4'(1 + $urandom_range(0, 14)), 2,
          4'h0, 4'h0, 32'h0);
    chk("viol_sat", {24'b0, wp_viol_cnt}, 32'd255);
    req(32'h20, 32'h0, 4'h0, 2, 4'hF, 4'h0, 32'h55667788);

    req(32'h0000_2000, 32'h0, 4'h0, 0, 4'h0, 4'h0, 32'h0);
    req(32'h0000_2000, 32'h12345678, 4'hF, 0, 4'h0, 4'h0, 32'h0);

    // reset hits the ACCESS cycle of a write
    wp_set = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h30;
    mem_wdata = 32'h0BADF00D;
    mem_wstrb = 4'hF;
    @(posedge clk); #1;
    chk("abort_pre_wre", {28'b0, ram_wre}, 32'hF);
    #2 resetn = 1'b0;
    #1;
    chk("abort_wre", {28'b0, ram_wre}, 32'h0);
    chk("abort_ce", {28'b0, ram_ce}, 32'h0);
    chk("abort_viol", {24'b0, wp_viol_cnt}, 32'h0);
    mem_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", {31'b0, mem_ready}, 32'h0);
    @(negedge clk); resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("abort_noready", {31'b0, mem_ready}, 32'h0);
    end
    req(32'h30, 32'h0, 4'h0, 2, 4'hF, 4'h0, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
